// File: rtl/up_down_counter_32.sv
// up_down_counter_32: loadable up/down counter with asynchronous active-high reset.
// Every rising edge either loads data, increments or decrements. There is no hold
// state. Arithmetic wraps modulo 2^WIDTH and overflow is not flagged.
module up_down_counter_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_out
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // A 1-bit counter cannot be both loadable and meaningfully bidirectional here.
  generate
    if (WIDTH < 2) begin : g_width_check
      $error("up_down_counter_32: WIDTH must be at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // Next-count selection: load has priority over direction.
  always_comb begin
    w_next = r_count;
    if (load) begin
      w_next = data;
    end else if (mode) begin
      w_next = r_count + ONE;
    end else begin
      w_next = r_count - ONE;
    end
  end

  // Count register. Reset clears it at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign data_out = r_count;

endmodule

// File: tb/tb_up_down_counter_32.sv
// Self-checking bench for up_down_counter_32: directed scenarios plus a randomized
// run checked against a plain-arithmetic reference count.
module tb_up_down_counter_32;

  logic        clk;
  logic        rst;
  logic        load;
  logic        mode;
  logic [31:0] data;
  logic [31:0] data_out;

  int n_tests;
  int n_fail;
  logic [31:0] m;

  up_down_counter_32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .mode     (mode),
    .data     (data),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then let one rising edge pass and settle.
  task automatic step(input logic r, input logic l, input logic md, input logic [31:0] d);
    @(negedge clk);
    rst  = r;
    load = l;
    mode = md;
    data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; mode = 1'b1; data = '0;
    #2;
    n_tests++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_initial: got %h expected %h", data_out, 32'h0);
    end
    step(1'b0, 1'b1, 1'b1, 32'h1234_5678);
    n_tests++;
    if (data_out !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL reset_preload: got %h expected %h", data_out, 32'h1234_5678);
    end
    // Mid-cycle assertion: clear must appear before the next edge.
    load = 1'b1; data = 32'hAAAA_AAAA;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", data_out, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 32'hAAAA_AAAA);
      n_tests++;
      if (data_out !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, data_out, 32'h0);
      end
    end
  endtask

  task automatic test_load_up();
    logic [31:0] exp_seq [6] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
    for (int i = 0; i < 6; i++) begin
      if (i == 0) step(1'b0, 1'b1, 1'b0, 32'h0000_0010);
      else        step(1'b0, 1'b0, 1'b1, 32'hFFFF_0000);
      n_tests++;
      if (data_out !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL load_up[%0d]: got %h expected %h", i, data_out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [31:0] exp_seq [4] = '{32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(1'b0, 1'b1, 1'b1, 32'h0000_0001);
      else        step(1'b0, 1'b0, 1'b0, 32'h5555_5555);
      n_tests++;
      if (data_out !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL down_wrap[%0d]: got %h expected %h", i, data_out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [31:0] exp_seq [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE);
      else        step(1'b0, 1'b0, 1'b1, 32'h0);
      n_tests++;
      if (data_out !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: got %h expected %h", i, data_out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_priority_dir();
    logic [31:0] exp_seq [4] = '{32'hDEAD_BEEF, 32'hDEAD_BEF0, 32'hDEAD_BEEF, 32'hDEAD_BEF0};
    logic        modes   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i == 0), modes[i], 32'hDEAD_BEEF);
      n_tests++;
      if (data_out !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL priority_dir[%0d]: got %h expected %h", i, data_out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'h0BAD_F00D, 32'h0000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, i[0], vals[i]);
      n_tests++;
      if (data_out !== vals[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, data_out, vals[i]);
      end
    end
    m = vals[2];
  endtask

  task automatic test_random();
    logic        r, l, md;
    logic [31:0] d;
    for (int i = 0; i < 100; i++) begin
      r  = ($urandom_range(0, 11) == 0);
      l  = ($urandom_range(0, 3) == 0);
      md = $urandom_range(0, 1) == 1;
      // Bias some loads toward the wrap boundaries.
      case ($urandom_range(0, 3))
        0:       d = 32'hFFFF_FFFF;
        1:       d = 32'h0;
        default: d = $urandom;
      endcase
      step(r, l, md, d);
      if (r)       m = 0;
      else if (l)  m = d;
      else if (md) m = m + 1;
      else         m = m - 1;
      n_tests++;
      if (data_out !== m) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h (rst=%0b load=%0b mode=%0b data=%h)",
                 i, data_out, m, r, l, md, d);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m       = '0;
    test_reset();
    test_load_up();
    test_down_wrap();
    test_up_wrap();
    test_priority_dir();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
